// File: rtl/id_issue_buffer.sv
// Decode-to-issue buffer: in-order circular queue presenting its NR_ISSUE oldest
// entries to the issue stage, with in-order acknowledge and flush.
module id_issue_buffer #(
   parameter int unsigned DATA_WIDTH = 256,
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned NR_ISSUE   = 2
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           flush_i,
   input  logic [DATA_WIDTH-1:0]          entry_i,
   input  logic                           entry_ctrl_flow_i,
   input  logic                           entry_valid_i,
   output logic                           entry_ready_o,
   output logic [NR_ISSUE*DATA_WIDTH-1:0] issue_entry_o,
   output logic [NR_ISSUE-1:0]            issue_ctrl_flow_o,
   output logic [NR_ISSUE-1:0]            issue_valid_o,
   input  logic [NR_ISSUE-1:0]            issue_ack_i,
   output logic [$clog2(DEPTH+1)-1:0]     count_o
);

   localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW    = $clog2(DEPTH + 1);
   localparam int unsigned MEM_N = 2 ** PW;

   if ((NR_ISSUE < 1) || (NR_ISSUE > 2) || (NR_ISSUE > DEPTH) ||
       ((DEPTH & (DEPTH - 1)) != 0)) begin : g_param_check
      $error("id_issue_buffer: need NR_ISSUE in 1..2, NR_ISSUE <= DEPTH, DEPTH power of two");
   end

   typedef logic [DATA_WIDTH:0] slot_t;   // {ctrl_flow, entry}

   slot_t           r_mem [MEM_N];
   logic [PW-1:0]   r_rd_ptr;
   logic [PW-1:0]   r_wr_ptr;
   logic [CW-1:0]   r_count;
   logic [CW-1:0]   w_n_ack;
   logic            w_push;

   // Pointers wrap modulo DEPTH; a one-deep queue keeps both pointers at slot 0.
   function automatic logic [PW-1:0] f_ptr_add(input logic [PW-1:0] ptr,
                                               input logic [CW-1:0] inc);
      logic [PW-1:0] sum;
      sum = ptr + PW'(inc);
      return (DEPTH == 1) ? '0 : sum;
   endfunction

   for (genvar k = 0; k < NR_ISSUE; k++) begin : g_issue
      logic [PW-1:0] w_idx;
      assign w_idx                                      = f_ptr_add(r_rd_ptr, CW'(k));
      assign issue_valid_o[k]                           = (r_count > CW'(k));
      assign issue_entry_o[k*DATA_WIDTH +: DATA_WIDTH]  = r_mem[w_idx][DATA_WIDTH-1:0];
      assign issue_ctrl_flow_o[k]                       = r_mem[w_idx][DATA_WIDTH];
   end

   // An ack only counts when every older slot is also acked and the slot is valid.
   always_comb begin
      logic w_chain;
      // NOTE: every combinational output gets a default first so no latch is inferred.
      w_chain = 1'b1;
      w_n_ack = '0;
      for (int k = 0; k < NR_ISSUE; k++) begin
         w_chain = w_chain & issue_ack_i[k] & issue_valid_o[k];
         w_n_ack = w_n_ack + CW'(w_chain);
      end
   end

   assign entry_ready_o = !rst_i && ((r_count - w_n_ack) < CW'(DEPTH));
   assign w_push        = entry_valid_i & entry_ready_o;
   assign count_o       = r_count;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         // NOTE: storage is reset too, so issue_entry_o reads zero after reset rather than X.
         for (int i = 0; i < MEM_N; i++) begin
            r_mem[i] <= '0;
         end
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (flush_i) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         if (w_push) begin
            r_mem[r_wr_ptr] <= {entry_ctrl_flow_i, entry_i};
            r_wr_ptr        <= f_ptr_add(r_wr_ptr, CW'(1));
         end
         r_rd_ptr <= f_ptr_add(r_rd_ptr, w_n_ack);
         r_count  <= r_count + CW'(w_push) - w_n_ack;
      end
   end

   always @(posedge clk_i) begin
      if (!rst_i) begin
         assert (r_count <= CW'(DEPTH));
      end
   end

endmodule

// File: doc/id_issue_buffer.md
Name: id_issue_buffer

Overview:
Parametrised decode-to-issue buffer that replaces the single ID/issue pipeline register.
- Holds up to DEPTH decoded instruction entries, each with its control-flow flag, in an in-order circular queue.
- Presents the NR_ISSUE oldest entries to the issue stage at once.
- Issue acknowledges them in order; a flush empties the queue.
- Sits between the decoder output and the issue stage.

Parameters:
DATA_WIDTH, 256, width of one decoded entry (packed scoreboard entry)
DEPTH, 4, number of queue slots; power of two, >= NR_ISSUE
NR_ISSUE, 2, number of issue ports presented in parallel; 1 or 2

Ports:
clk_i  input  1  clock, all state on rising edge
rst_i  input  1  synchronous reset, active-high
flush_i  input  1  discard all buffered entries
entry_i  input  DATA_WIDTH  decoded entry from decoder
entry_ctrl_flow_i  input  1  entry_i is a control-flow instruction
entry_valid_i  input  1  entry_i valid
entry_ready_o  output  1  buffer accepts entry_i this cycle
issue_entry_o  output  NR_ISSUE*DATA_WIDTH  slot k at bits [k*DATA_WIDTH +: DATA_WIDTH]; slot 0 is oldest
issue_ctrl_flow_o  output  NR_ISSUE  control-flow flag per issue slot
issue_valid_o  output  NR_ISSUE  issue slot k holds a valid entry
issue_ack_i  input  NR_ISSUE  issue stage consumes slot k this cycle
count_o  output  $clog2(DEPTH+1)  current occupancy (registered)

Behaviour:
- State:
  - rd_ptr, wr_ptr: $clog2(DEPTH) bits, wrap modulo DEPTH.
  - count_q: 0..DEPTH.
  - Storage: DEPTH x (DATA_WIDTH+1).
- Reset (rst_i=1 at clock edge):
  - rd_ptr, wr_ptr, count_q and all storage cleared to 0.
  - Outputs after reset: issue_valid_o=0, issue_entry_o=0, issue_ctrl_flow_o=0, count_o=0.
  - entry_ready_o is forced 0 while rst_i=1.
  - A reset mid-operation drops all entries; no handshake in that cycle takes effect.
- Issue outputs (combinational from registers only):
  - issue_valid_o[k] = (count_q > k).
  - Slot k shows storage[(rd_ptr+k) mod DEPTH].
- Ack qualification:
  - eff_ack0 = issue_ack_i[0] & issue_valid_o[0].
  - eff_ack1 = issue_ack_i[1] & issue_valid_o[1] & eff_ack0.
  - An ack on slot 1 without an ack on slot 0 is ignored; an ack on an invalid slot is ignored.
  - n_ack = eff_ack0 + eff_ack1.
- Accept rule:
  - entry_ready_o = !rst_i & ((count_q - n_ack) < DEPTH).
  - The ready path depends combinationally on issue_ack_i, so a full buffer accepts in the same cycle it is acknowledged.
  - push = entry_valid_i & entry_ready_o.
- Update (no flush):
  - push writes {entry_ctrl_flow_i, entry_i} at wr_ptr and increments wr_ptr.
  - rd_ptr += n_ack.
  - count_q += push - n_ack.
  - Simultaneous push and ack at any occupancy is legal.
- Latency: an entry accepted in cycle N appears on the issue outputs in cycle N+1, never in cycle N (no bypass).
- Flush:
  - flush_i=1 sets count_q, rd_ptr and wr_ptr to 0 at the next edge.
  - An entry handshaked in the flush cycle is consumed upstream but discarded.
  - Acks in the flush cycle have no further effect.
  - Storage is not cleared.
  - Flush has priority over push and ack.
- Empty: issue_valid_o=0 and issue_entry_o shows stale storage; consumers qualify with valid.
- Full: count_q=DEPTH; entry_ready_o=0 unless eff_ack0=1.
- DEPTH=1 with NR_ISSUE=1 degenerates to a single ID/issue register with ack-through accept.
- Assertions:
  - count_q <= DEPTH.
  - An ack on slot 1 without an ack on slot 0 flags a bench warning.
  - NR_ISSUE <= DEPTH (elaboration check).

Test Plan:
- Reset then fill (DEPTH=4, NR_ISSUE=2), no acks:
  - Push A,B,C,D, one per cycle.
  - Required: count_o=1,2,3,4 on successive cycles; entry_ready_o=0 once count_o=4.
  - A and B are visible on slots 0 and 1 from the cycle after the pushes of A and B respectively.
- Dual issue:
  - With A..D buffered, ack=2'b11.
  - Required: next cycle slot0=C, slot1=D, count_o=2.
  - Ack=2'b10 (slot 1 only) is then ignored: count stays 2.
- Full with simultaneous ack:
  - count=4, ack=2'b01, push E in the same cycle.
  - Required: entry_ready_o=1 combinationally; next cycle count=4, slot0=B.
  - Wrap-around: after 8 more push/ack pairs, the FIFO order is preserved through pointer wrap.
- Flush during push:
  - count=3, flush_i=1 with push X and ack=2'b01.
  - Required: next cycle count_o=0, issue_valid_o=0.
  - The next push Y appears at slot 0 one cycle later.
- Control-flow flag: push entries with ctrl_flow pattern 1,0,1; issue_ctrl_flow_o tracks each entry through slots 1 and 0.
- Reset mid-operation and NR_ISSUE=1/DEPTH=1 build:
  - rst_i=1 with count=3 -> count_o=0, issue outputs 0.
  - DEPTH=1 build: push while valid and acked in the same cycle is accepted, and the new entry is visible the next cycle.
